// File: rtl/branch_predict_table_pkg.sv
// Shared definitions for the branch target buffer: default geometry and the
// 2-bit direction counter encodings.
package branch_predict_table_pkg;

    localparam int IDX_W_DEF = 4;
    localparam int PC_W_DEF  = 32;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    localparam cnt_e CNT_RST = CNT_WNT;

endpackage

// File: rtl/branch_predict_table_if.sv
// Fetch/resolve bus between the pipeline and the branch target buffer.
// master = pipeline side (fetch PC, stage control, resolved branch info),
// slave  = predictor side (lookup results and delayed-stage copies).
interface branch_predict_table_if
    import branch_predict_table_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic [PC_W-1:0] pc_if;
    logic            stall;
    logic            flush;
    logic            H;
    logic            P;
    logic [PC_W-1:0] target;
    logic            Hd;
    logic            Pd;
    logic [PC_W-1:0] target_d;
    logic [PC_W-1:0] pc_d;
    logic            WRt;
    logic            WRp;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;

    modport master (
        output pc_if, stall, flush, WRt, WRp, upd_target, upd_taken,
        input  H, P, target, Hd, Pd, target_d, pc_d
    );

    modport slave (
        input  pc_if, stall, flush, WRt, WRp, upd_target, upd_taken,
        output H, P, target, Hd, Pd, target_d, pc_d
    );
endinterface

// File: rtl/branch_predict_table_sat_counter2.sv
// 2-bit saturating counter next-state: moves toward strongly-taken on a
// taken branch, toward strongly-not-taken otherwise, never wrapping.
module sat_counter2
    import branch_predict_table_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_nxt
);

    // Saturating increment/decrement
    always_comb begin
        cnt_nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) cnt_nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_table.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational from the fetch PC; a delayed copy of the lookup
// follows the branch to resolve, where its PC addresses allocation/training.
module branch_predict_table
    import branch_predict_table_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int PC_W  = PC_W_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    branch_predict_table_if.slave bus
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    // Entry storage; only valid/cnt carry reset, tag/target are don't-care
    // while their entry is invalid.
    logic             valid      [ENTRIES];
    logic [TAG_W-1:0] tag_mem    [ENTRIES];
    logic [PC_W-1:0]  target_mem [ENTRIES];
    logic [1:0]       cnt_mem    [ENTRIES];

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_u;
    logic [TAG_W-1:0] tag_l;
    logic [TAG_W-1:0] tag_u;
    logic             hit;
    logic             upd_hit;
    logic [1:0]       cnt_nxt;

    logic             hd_r;
    logic             pd_r;
    logic [PC_W-1:0]  target_d_r;
    logic [PC_W-1:0]  pc_d_r;

    // Byte-offset bits of word-aligned PCs carry no information.
    logic unused_bits;
    assign unused_bits = ^{bus.pc_if[1:0], pc_d_r[1:0]};

    assign idx   = bus.pc_if[IDX_W+1:2];
    assign tag_l = bus.pc_if[PC_W-1:IDX_W+2];
    assign idx_u = pc_d_r[IDX_W+1:2];
    assign tag_u = pc_d_r[PC_W-1:IDX_W+2];

    // Lookup reads the array as it stands; a write this cycle shows next cycle.
    assign hit     = valid[idx] && (tag_mem[idx] == tag_l);
    assign upd_hit = valid[idx_u] && (tag_mem[idx_u] == tag_u);

    assign bus.H        = hit;
    assign bus.P        = hit && cnt_mem[idx][1];
    assign bus.target   = hit ? target_mem[idx] : '0;
    assign bus.Hd       = hd_r;
    assign bus.Pd       = pd_r;
    assign bus.target_d = target_d_r;
    assign bus.pc_d     = pc_d_r;

    sat_counter2 u_sat (
        .cnt     (cnt_mem[idx_u]),
        .taken   (bus.upd_taken),
        .cnt_nxt (cnt_nxt)
    );

    // Delayed stage: flush kills the prediction but still tracks the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_r       <= 1'b0;
            pd_r       <= 1'b0;
            target_d_r <= '0;
            pc_d_r     <= '0;
        end else if (bus.flush) begin
            hd_r       <= 1'b0;
            pd_r       <= 1'b0;
            target_d_r <= '0;
            pc_d_r     <= bus.pc_if;
        end else if (!bus.stall) begin
            hd_r       <= bus.H;
            pd_r       <= bus.P;
            target_d_r <= bus.target;
            pc_d_r     <= bus.pc_if;
        end
    end

    // Valid bits and counters: allocate with a weak counter, or train on a tag match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                cnt_mem[i] <= CNT_RST;
            end
        end else if (bus.WRt) begin
            valid[idx_u]   <= 1'b1;
            cnt_mem[idx_u] <= bus.upd_taken ? CNT_WT : CNT_WNT;
        end else if (bus.WRp && upd_hit) begin
            cnt_mem[idx_u] <= cnt_nxt;
        end
    end

    // Tag and target payload on allocation; aliasing entries are simply overwritten.
    always_ff @(posedge clk) begin
        if (bus.WRt) begin
            tag_mem[idx_u]    <= tag_u;
            target_mem[idx_u] <= bus.upd_target;
        end
    end

endmodule

// File: tb/tb_branch_predict_table.sv
// Bench for branch_predict_table: directed scenarios plus randomized traffic
// checked against a behavioural model of the predictor.
module tb_branch_predict_table;

    localparam int IDX_W   = 4;
    localparam int PC_W    = 32;
    localparam int ENTRIES = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    branch_predict_table_if #(.PC_W(PC_W)) bus();

    branch_predict_table #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    bit          m_hd, m_pd;
    logic [31:0] m_td, m_pcd;

    function automatic int ix(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tg(logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[ix(pc)] && (m_tag[ix(pc)] == tg(pc));
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_hit(pc) && (m_cnt[ix(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(logic [31:0] pc);
        return m_hit(pc) ? m_tgt[ix(pc)] : 32'h0;
    endfunction

    function automatic int sat_step(int c, bit tk);
        if (tk) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] <= 1'b0;
                m_cnt[i]   <= 1;
            end
            m_hd  <= 1'b0;
            m_pd  <= 1'b0;
            m_td  <= 32'h0;
            m_pcd <= 32'h0;
        end else begin
            if (bus.flush) begin
                m_hd  <= 1'b0;
                m_pd  <= 1'b0;
                m_td  <= 32'h0;
                m_pcd <= bus.pc_if;
            end else if (!bus.stall) begin
                m_hd  <= m_hit(bus.pc_if);
                m_pd  <= m_pred(bus.pc_if);
                m_td  <= m_target(bus.pc_if);
                m_pcd <= bus.pc_if;
            end
            if (bus.WRt) begin
                m_valid[ix(m_pcd)] <= 1'b1;
                m_tag[ix(m_pcd)]   <= tg(m_pcd);
                m_tgt[ix(m_pcd)]   <= bus.upd_target;
                m_cnt[ix(m_pcd)]   <= bus.upd_taken ? 2 : 1;
            end else if (bus.WRp && m_hit(m_pcd)) begin
                m_cnt[ix(m_pcd)] <= sat_step(m_cnt[ix(m_pcd)], bus.upd_taken);
            end
        end
    end

    task automatic drive(input logic [31:0] pc, input logic st, input logic fl,
                         input logic wt, input logic wp, input logic [31:0] ut,
                         input logic tk);
        bus.pc_if      = pc;
        bus.stall      = st;
        bus.flush      = fl;
        bus.WRt        = wt;
        bus.WRp        = wp;
        bus.upd_target = ut;
        bus.upd_taken  = tk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.H !== 1'b0) begin bad++; $display("FAIL reset_H got=%b want=0", bus.H); end
        total++; if (bus.P !== 1'b0) begin bad++; $display("FAIL reset_P got=%b want=0", bus.P); end
        total++; if (bus.target !== 32'h0) begin bad++; $display("FAIL reset_target got=%h want=0", bus.target); end
        step();
        total++; if (bus.Hd !== 1'b0) begin bad++; $display("FAIL reset_Hd got=%b want=0", bus.Hd); end
        total++; if (bus.Pd !== 1'b0) begin bad++; $display("FAIL reset_Pd got=%b want=0", bus.Pd); end
        total++; if (bus.pc_d !== 32'h0) begin bad++; $display("FAIL reset_pc_d got=%h want=0", bus.pc_d); end
        rst_n = 1'b1;
    endtask

    task automatic test_alloc();
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
        step();
        total++; if (bus.pc_d !== 32'h40) begin bad++; $display("FAIL alloc_pc_d got=%h want=40", bus.pc_d); end
        total++; if (bus.Hd !== 1'b0) begin bad++; $display("FAIL alloc_Hd_miss got=%b want=0", bus.Hd); end
        drive(32'h44, 0, 0, 1, 0, 32'h100, 1);
        step();
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.H !== 1'b1) begin bad++; $display("FAIL alloc_H got=%b want=1", bus.H); end
        total++; if (bus.P !== 1'b1) begin bad++; $display("FAIL alloc_P got=%b want=1", bus.P); end
        total++; if (bus.target !== 32'h100) begin bad++; $display("FAIL alloc_target got=%h want=100", bus.target); end
    endtask

    task automatic test_train();
        bit tk  [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
        bit exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
        step();
        total++; if (bus.Hd !== 1'b1) begin bad++; $display("FAIL train_Hd got=%b want=1", bus.Hd); end
        total++; if (bus.Pd !== 1'b1) begin bad++; $display("FAIL train_Pd got=%b want=1", bus.Pd); end
        total++; if (bus.target_d !== 32'h100) begin bad++; $display("FAIL train_target_d got=%h want=100", bus.target_d); end
        for (int i = 0; i < 9; i++) begin
            drive(32'h40, 0, 0, 0, 1, 32'h0, tk[i]);
            step();
            total++; if (bus.H !== 1'b1) begin bad++; $display("FAIL train_H[%0d] got=%b want=1", i, bus.H); end
            total++; if (bus.P !== exp[i]) begin bad++; $display("FAIL train_P[%0d] got=%b want=%b", i, bus.P, exp[i]); end
        end
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic test_alias();
        drive(32'h440, 0, 0, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.H !== 1'b0) begin bad++; $display("FAIL alias_H_before got=%b want=0", bus.H); end
        step();
        drive(32'h440, 0, 0, 1, 0, 32'h200, 0);
        step();
        drive(32'h440, 0, 0, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.H !== 1'b1) begin bad++; $display("FAIL alias_H_new got=%b want=1", bus.H); end
        total++; if (bus.P !== 1'b0) begin bad++; $display("FAIL alias_P_new got=%b want=0", bus.P); end
        total++; if (bus.target !== 32'h200) begin bad++; $display("FAIL alias_target got=%h want=200", bus.target); end
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.H !== 1'b0) begin bad++; $display("FAIL alias_evicted_H got=%b want=0", bus.H); end
        step();
        // Training with a stale tag must leave the resident entry alone.
        drive(32'h40, 0, 0, 0, 1, 32'h0, 1);
        step();
        step();
        drive(32'h440, 0, 0, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.P !== 1'b0) begin bad++; $display("FAIL alias_train_miss_P got=%b want=0", bus.P); end
    endtask

    task automatic test_flush_stall();
        drive(32'h48, 0, 0, 0, 0, 32'h0, 0);
        step();
        drive(32'h48, 0, 0, 1, 0, 32'h300, 1);
        step();
        drive(32'h48, 0, 0, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.H !== 1'b1 || bus.P !== 1'b1) begin bad++; $display("FAIL fs_lookup got=%b%b want=11", bus.H, bus.P); end
        step();
        total++; if (bus.Hd !== 1'b1 || bus.Pd !== 1'b1) begin bad++; $display("FAIL fs_capture got=%b%b want=11", bus.Hd, bus.Pd); end
        drive(32'h4C, 1, 0, 0, 0, 32'h0, 0);
        step();
        total++; if (bus.Hd !== 1'b1 || bus.Pd !== 1'b1) begin bad++; $display("FAIL fs_stall_HdPd got=%b%b want=11", bus.Hd, bus.Pd); end
        total++; if (bus.target_d !== 32'h300) begin bad++; $display("FAIL fs_stall_target_d got=%h want=300", bus.target_d); end
        total++; if (bus.pc_d !== 32'h48) begin bad++; $display("FAIL fs_stall_pc_d got=%h want=48", bus.pc_d); end
        drive(32'h4C, 0, 0, 0, 0, 32'h0, 0);
        step();
        total++; if (bus.pc_d !== 32'h4C) begin bad++; $display("FAIL fs_run_pc_d got=%h want=4c", bus.pc_d); end
        drive(32'h48, 1, 1, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.H !== 1'b1) begin bad++; $display("FAIL fs_flush_H got=%b want=1", bus.H); end
        step();
        total++; if (bus.Hd !== 1'b0 || bus.Pd !== 1'b0) begin bad++; $display("FAIL fs_flush_HdPd got=%b%b want=00", bus.Hd, bus.Pd); end
        total++; if (bus.target_d !== 32'h0) begin bad++; $display("FAIL fs_flush_target_d got=%h want=0", bus.target_d); end
        total++; if (bus.pc_d !== 32'h48) begin bad++; $display("FAIL fs_flush_pc_d got=%h want=48", bus.pc_d); end
        drive(32'h48, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic test_same_cycle();
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
        step();
        drive(32'h40, 0, 0, 1, 0, 32'h180, 1);
        #1;
        total++; if (bus.H !== 1'b0) begin bad++; $display("FAIL same_H_old got=%b want=0", bus.H); end
        step();
        total++; if (bus.H !== 1'b1) begin bad++; $display("FAIL same_H_new got=%b want=1", bus.H); end
        total++; if (bus.target !== 32'h180) begin bad++; $display("FAIL same_target got=%h want=180", bus.target); end
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic test_reset_mid();
        drive(32'h48, 0, 0, 1, 0, 32'h500, 0);
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.H !== 1'b0) begin bad++; $display("FAIL rmid_H got=%b want=0", bus.H); end
        total++; if (bus.pc_d !== 32'h0) begin bad++; $display("FAIL rmid_pc_d got=%h want=0", bus.pc_d); end
        step();
        rst_n = 1'b1;
        drive(32'h40, 0, 0, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.H !== 1'b0) begin bad++; $display("FAIL rmid_H_40 got=%b want=0", bus.H); end
        drive(32'h48, 0, 0, 0, 0, 32'h0, 0);
        #1;
        total++; if (bus.H !== 1'b0) begin bad++; $display("FAIL rmid_H_48 got=%b want=0", bus.H); end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int n = 0; n < 500; n++) begin
            pc = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            drive(pc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                  $urandom, $urandom_range(0, 1));
            #1;
            total++; if (bus.H !== m_hit(pc)) begin bad++; $display("FAIL rnd_H[%0d] got=%b want=%b", n, bus.H, m_hit(pc)); end
            total++; if (bus.P !== m_pred(pc)) begin bad++; $display("FAIL rnd_P[%0d] got=%b want=%b", n, bus.P, m_pred(pc)); end
            total++; if (bus.target !== m_target(pc)) begin bad++; $display("FAIL rnd_target[%0d] got=%h want=%h", n, bus.target, m_target(pc)); end
            total++; if (bus.Hd !== m_hd || bus.Pd !== m_pd) begin bad++; $display("FAIL rnd_HdPd[%0d] got=%b%b want=%b%b", n, bus.Hd, bus.Pd, m_hd, m_pd); end
            total++; if (bus.target_d !== m_td) begin bad++; $display("FAIL rnd_target_d[%0d] got=%h want=%h", n, bus.target_d, m_td); end
            total++; if (bus.pc_d !== m_pcd) begin bad++; $display("FAIL rnd_pc_d[%0d] got=%h want=%h", n, bus.pc_d, m_pcd); end
            step();
        end
        drive(32'h0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        drive(32'h0, 0, 0, 0, 0, 32'h0, 0);
        test_reset();
        test_alloc();
        test_train();
        test_alias();
        test_flush_stall();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
